// File: rtl/sar_tnh_ctrl_pkg.sv
// Shared types and helpers for the SAR track-and-hold controller.
// Covers the FSM state encoding, counter sizing and trial-code arithmetic.
package sar_tnh_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, CONV, DONE} sar_state_t;

    localparam int MAX_BITS = 32;

    // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_BITS-1:0] trial_code(input logic [MAX_BITS-1:0] result,
                                                       input int                  idx);
        return result | (MAX_BITS'(1) << idx);
    endfunction

endpackage

// File: rtl/sar_tnh_ctrl_if.sv
// Result handshake between the SAR controller and the digital back-end.
// Carries the converted code plus its valid/ready pair.
interface sar_tnh_ctrl_if #(
    parameter int N_BITS = 8
);
    logic [N_BITS-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/sar_tnh_ctrl_reg.sv
// Successive-approximation register: it holds the partial result and
// registers the trial code that drives the reference DAC.
module sar_tnh_ctrl_reg
    import sar_tnh_ctrl_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_init,
    input  logic                       i_load,
    input  logic [cnt_w(N_BITS)-1:0]   i_idx,
    input  logic                       i_cmp,
    output logic [N_BITS-1:0]          o_result_next,
    output logic [N_BITS-1:0]          o_trial
);

    logic [N_BITS-1:0] r_result;
    logic [N_BITS-1:0] r_trial;
    logic [N_BITS-1:0] w_keep;

    // Bit idx is still clear in r_result, so OR-ing in the decision is enough.
    assign w_keep        = {{(N_BITS-1){1'b0}}, i_cmp} << i_idx;
    assign o_result_next = r_result | w_keep;
    assign o_trial       = r_trial;

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_result <= '0;
            r_trial  <= '0;
        end else if (i_init) begin
            r_result <= '0;
            r_trial  <= N_BITS'(trial_code('0, N_BITS - 1));
        end else if (i_load) begin
            r_result <= o_result_next;
            r_trial  <= (i_idx == '0) ? '0
                      : N_BITS'(trial_code(MAX_BITS'(o_result_next), int'(i_idx) - 1));
        end
    end

endmodule

// File: rtl/sar_tnh_ctrl.sv
// Track-and-hold clocking and SAR conversion controller with a
// valid/ready result port; all outputs come straight from flops.
module sar_tnh_ctrl
    import sar_tnh_ctrl_pkg::*;
#(
    parameter int N_BITS        = 8,
    parameter int TRACK_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              sclk,
    output logic [N_BITS-1:0] dac_code,
    input  logic              cmp,
    output logic              busy,
    sar_tnh_ctrl_if.master    dout_if
);

    localparam int TW = cnt_w(TRACK_CYCLES);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam int IW = cnt_w(N_BITS);

    sar_state_t        r_state, w_state_nxt;
    logic [TW-1:0]     r_tcnt;
    logic [SW-1:0]     r_scnt;
    logic [IW-1:0]     r_idx;
    logic              r_sclk, r_busy, r_dout_valid;
    logic [N_BITS-1:0] r_dout;
    logic [N_BITS-1:0] w_result_next;
    logic              w_trk_done, w_trial_end, w_last_bit, w_hs, w_init, w_load, w_finish;

    assign w_trk_done  = (r_tcnt == TW'(TRACK_CYCLES - 1));
    assign w_trial_end = (r_scnt == SW'(SETTLE_CYCLES - 1));
    assign w_last_bit  = (r_idx == '0);
    assign w_hs        = r_dout_valid & dout_if.dout_ready;
    assign w_finish    = w_load & w_last_bit;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = TRACK;
            TRACK:   if (w_trk_done) begin
                         w_state_nxt = CONV;
                         w_init      = 1'b1;
                     end
            CONV:    if (w_trial_end) begin
                         w_load = 1'b1;
                         if (w_last_bit) w_state_nxt = DONE;
                     end
            DONE:    if (w_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Counters hold at terminal count; the FSM moves on from there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= '0;
            r_scnt <= '0;
            r_idx  <= '0;
        end else begin
            if (r_state == IDLE)                   r_tcnt <= '0;
            else if (r_state == TRACK && !w_trk_done) r_tcnt <= r_tcnt + TW'(1);

            if (w_init || w_load)                  r_scnt <= '0;
            else if (r_state == CONV && !w_trial_end) r_scnt <= r_scnt + SW'(1);

            if (w_init)                            r_idx <= IW'(N_BITS - 1);
            else if (w_load && !w_last_bit)        r_idx <= r_idx - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk       <= 1'b0;
            r_busy       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            if (w_init)        r_sclk <= 1'b1;
            else if (w_finish) r_sclk <= 1'b0;
            if (w_finish) begin
                r_dout       <= w_result_next;
                r_dout_valid <= 1'b1;
            end else if (w_hs) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    sar_tnh_ctrl_reg #(.N_BITS(N_BITS)) u_sar_reg (
        .clk           (clk),
        .rstn          (rstn),
        .i_init        (w_init),
        .i_load        (w_load),
        .i_idx         (r_idx),
        .i_cmp         (cmp),
        .o_result_next (w_result_next),
        .o_trial       (dac_code)
    );

    assign sclk               = r_sclk;
    assign busy               = r_busy;
    assign dout_if.dout       = r_dout;
    assign dout_if.dout_valid = r_dout_valid;

endmodule
